// File: rtl/register_file_32.sv
// 32-entry register file with an internal 5-to-32 write decoder; index 31 is the hardwired zero register.
// Optional macro REGFILE_BYPASS_EN enables same-cycle write-through forwarding to both read ports.

module decoder_5to32 (
  input  logic [4:0]  select,
  input  logic        write_en,
  output logic [31:0] onehot
);

  always_comb begin
    onehot         = '0;
    onehot[select] = write_en;
  end

endmodule

module register_file_32 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write_en,
  input  logic [4:0]       write_reg,
  input  logic [WIDTH-1:0] write_data,
  input  logic [4:0]       read_reg1,
  input  logic [4:0]       read_reg2,
  output logic [WIDTH-1:0] read_data1,
  output logic [WIDTH-1:0] read_data2
);

  localparam logic [4:0] ZERO_REG = 5'd31;

  logic [WIDTH-1:0] regs [0:30];
  logic [31:0]      dec;
  logic [30:0]      wr_sel;
  logic             dec_unused;

  decoder_5to32 u_decoder (
    .select   (write_reg),
    .write_en (write_en),
    .onehot   (dec)
  );

  // Bit 31 targets the zero register, which has no storage.
  assign wr_sel     = dec[30:0];
  assign dec_unused = dec[31];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 31; k++) regs[k] <= '0;
    end else begin
      for (int k = 0; k < 31; k++) begin
        if (wr_sel[k]) regs[k] <= write_data;
      end
    end
  end

  // Reset and the zero register dominate forwarding and stored contents.
  function automatic logic [WIDTH-1:0] read_port(input logic [4:0] idx);
    logic [WIDTH-1:0] value;
    if (reset || idx == ZERO_REG) begin
      value = '0;
    end
`ifdef REGFILE_BYPASS_EN
    else if (write_en && write_reg != ZERO_REG && idx == write_reg) begin
      value = write_data;
    end
`endif
    else begin
      value = regs[idx];
    end
    return value;
  endfunction

  always_comb begin
    read_data1 = read_port(read_reg1);
    read_data2 = read_port(read_reg2);
  end

endmodule

// File: tb/tb_register_file_32.sv
// Directed self-checking bench for register_file_32; expected values are hand-computed constants.
// Same-cycle read-during-write expectations follow REGFILE_BYPASS_EN.

module tb_register_file_32;

  localparam int WIDTH = 64;

  logic             clk;
  logic             reset;
  logic             write_en;
  logic [4:0]       write_reg;
  logic [WIDTH-1:0] write_data;
  logic [4:0]       read_reg1;
  logic [4:0]       read_reg2;
  logic [WIDTH-1:0] read_data1;
  logic [WIDTH-1:0] read_data2;

  int n_cmp = 0;
  int n_bad = 0;

  register_file_32 #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .write_en   (write_en),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Commits one write on the posedge between two negedges.
  task automatic do_write(input logic [4:0] idx, input logic [WIDTH-1:0] data, input logic en);
    @(negedge clk);
    write_en   = en;
    write_reg  = idx;
    write_data = data;
    @(negedge clk);
    write_en   = 1'b0;
  endtask

  task automatic read_pair(input string tag, input logic [4:0] i1, input logic [4:0] i2,
                           input logic [WIDTH-1:0] e1, input logic [WIDTH-1:0] e2);
    @(negedge clk);
    read_reg1 = i1;
    read_reg2 = i2;
    #1;
    check({tag, "_rd1"}, read_data1, e1);
    check({tag, "_rd2"}, read_data2, e2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] exp_same;

    reset      = 1'b1;
    write_en   = 1'b0;
    write_reg  = '0;
    write_data = '0;
    read_reg1  = 5'd0;
    read_reg2  = 5'd31;
    #1;
    check("reset_rd1", read_data1, '0);
    check("reset_rd2", read_data2, '0);

    // Unknown write enable while in reset must not leave anything behind.
    @(negedge clk);
    write_en   = 1'bx;
    write_reg  = 5'd3;
    write_data = 64'h1234;
    @(negedge clk);
    write_en = 1'b0;
    reset    = 1'b0;

    for (int i = 0; i < 32; i++)
      read_pair("post_reset_all", 5'(i), 5'(31 - i), '0, '0);

    // Plain write then read on both ports.
    do_write(5'd5, 64'hDEAD_BEEF_0123_4567, 1'b1);
    read_pair("x5_both", 5'd5, 5'd5, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567);
    for (int i = 0; i < 32; i++)
      if (i != 5) read_pair("others_zero", 5'(i), 5'(i), '0, '0);

    // Writes to the zero register are dropped.
    do_write(5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    read_pair("xzr_write", 5'd31, 5'd5, '0, 64'hDEAD_BEEF_0123_4567);
    read_pair("xzr_side", 5'd0, 5'd30, '0, '0);

    // Same-cycle read during write.
    do_write(5'd7, 64'h11, 1'b1);
    @(negedge clk);
    write_en   = 1'b1;
    write_reg  = 5'd7;
    write_data = 64'h42;
    read_reg1  = 5'd7;
    read_reg2  = 5'd5;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_same = 64'h42;
`else
    exp_same = 64'h11;
`endif
    check("rdw_before", read_data1, exp_same);
    check("rdw_other_port", read_data2, 64'hDEAD_BEEF_0123_4567);
    @(posedge clk);
    #1;
    check("rdw_after", read_data1, 64'h42);
    @(negedge clk);
    write_reg  = 5'd31;
    write_data = 64'h99;
    read_reg1  = 5'd31;
    #1;
    check("xzr_no_forward", read_data1, '0);
    @(negedge clk);
    write_en = 1'b0;

    // Sweep all enable/index combinations after a fresh reset.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) do_write(5'(i), WIDTH'(i + 1), 1'b0);
    for (int i = 0; i < 32; i++) read_pair("sweep_en0", 5'(i), 5'(i), '0, '0);
    for (int i = 0; i < 32; i++) do_write(5'(i), WIDTH'(i + 1), 1'b1);
    for (int i = 0; i < 31; i++)
      read_pair("sweep_en1", 5'(i), 5'(30 - i), WIDTH'(i + 1), WIDTH'(31 - i));
    read_pair("sweep_xzr", 5'd31, 5'd31, '0, '0);

    // Reset asserted between edges while a write is pending.
    do_write(5'd10, 64'hA5, 1'b1);
    read_pair("x10_loaded", 5'd10, 5'd3, 64'hA5, 64'h4);
    @(negedge clk);
    write_en   = 1'b1;
    write_reg  = 5'd10;
    write_data = 64'h5A;
    read_reg1  = 5'd10;
    read_reg2  = 5'd10;
    #2;
    reset = 1'b1;
    #1;
    check("async_clear_rd1", read_data1, '0);
    check("async_clear_rd2", read_data2, '0);
    @(negedge clk);
    reset     = 1'b0;
    write_en  = 1'b0;
    #1;
    check("x10_after_reset", read_data1, '0);
    read_pair("x3_after_reset", 5'd3, 5'd30, '0, '0);

    // First write after deassertion commits on the next edge.
    @(negedge clk);
    reset = 1'b1;
    write_en   = 1'b1;
    write_reg  = 5'd4;
    write_data = 64'h77;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    write_en = 1'b0;
    read_pair("first_write", 5'd4, 5'd4, 64'h77, 64'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/register_file_32.md
Name: register_file_32

Overview:
- 32-entry architectural register file for the pipelined CPU.
- Sits directly downstream of the 5-to-32 write decoder, which is instantiated inside this block.
- The writeback stage drives one write port. The decode stage reads two operands combinationally.
- Register 31 is the hardwired zero register (XZR).

Parameters:
WIDTH, 64, data width of each register in bits.

Ports:
clk  input  1  system clock; writes are committed on the rising edge.
reset  input  1  asynchronous, active-high reset; clears all registers.
write_en  input  1  writeback stage requests a register write this cycle.
write_reg  input  5  destination register index for the write.
write_data  input  WIDTH  value to be written.
read_reg1  input  5  source index for operand 1.
read_reg2  input  5  source index for operand 2.
read_data1  output  WIDTH  operand 1 value (combinational).
read_data2  output  WIDTH  operand 2 value (combinational).

Behaviour:
- Clock and reset:
  - One clock, clk.
  - reset is asynchronous and active-high.
- Storage: 31 physical registers, indices 0..30, each WIDTH bits. Index 31 has no storage.
- Write decode:
  - Drive the internal decoder_5to32 with select = write_reg and write_en = write_en.
  - Its one-hot output gates the per-register enables.
  - Decoder output bit 31 is left unconnected.
- Write timing:
  - On posedge clk with reset low, register k loads write_data when decoder bit k = 1 (k = 0..30).
  - Write latency is 1 cycle: the new value is visible on the read ports from the cycle after the edge.
- Zero register:
  - A write to index 31 is a no-op.
  - A read of index 31 always returns 0, regardless of reset, bypass or write activity.
- Reads:
  - Purely combinational, with no clock latency.
  - read_dataN = contents[read_regN] for indices 0..30.
  - Both ports may address the same register; both then return the same value.
- Reset:
  - Asserting reset immediately clears registers 0..30 to 0, with no clock edge needed.
  - While reset is high:
    - All writes are ignored.
    - Both read ports output 0.
  - Reset asserted mid-operation, including in the same cycle as a write, discards that write.
  - On deassertion, the first write commits on the first rising edge at which reset is low.
- Read during write, same index, without bypass: the read port returns the old value until the edge, then the new value.
- Widths: no truncation or extension; write_data is stored exactly as WIDTH bits.
- Unknown inputs:
  - X on write_en must not corrupt any register while reset is high.
  - Outside reset, X behaviour is undefined and is not checked.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding is enabled.
  - If write_en = 1, reset = 0, write_reg != 31 and read_regN == write_reg, then read_dataN = write_data combinationally in the same cycle.
  - This removes the writeback-to-decode hazard.
  - Forwarding applies independently to each read port.
- Not defined: no forwarding. Reads always reflect stored contents, and the pipeline's hazard unit must insert one stall cycle.
- In both builds, reset and zero-register rules take priority over forwarding.

Test Plan:
- Reset, then read all 32 indices on both ports -> every read_data = 0.
- Write 64'hDEAD_BEEF_0123_4567 to X5, next cycle read_reg1 = 5 and read_reg2 = 5 -> both return 64'hDEAD_BEEF_0123_4567. All other indices remain 0.
- Write 64'hFFFF_FFFF_FFFF_FFFF to X31, then read index 31 -> 0. Also check that no other register changed.
- Same-cycle write of 64'h42 to X7 with read_reg1 = 7, X7 previously 64'h11:
  - Without REGFILE_BYPASS_EN, read_data1 = 64'h11 before the edge and 64'h42 after.
  - With REGFILE_BYPASS_EN, read_data1 = 64'h42 before the edge.
- Sweep write_en/write_reg over all 64 combinations with write_data = index + 1, then read back:
  - X0..X30 hold index + 1 only where write_en was 1.
  - Entries with write_en = 0 are untouched.
  - X31 reads 0.
- Load X10 = 64'hA5, then assert reset mid-cycle between edges while issuing a write of 64'h5A to X10:
  - read_data goes to 0 immediately.
  - After deassertion, X10 reads 0.
